seq_det: RTL and testbench
==========================

SEQ_DET -- requirements
Module: seq_det

Interface
REQ-001 SHALL have one parameter: CNT_W, default 8, the width of the detection counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port x, input, 1 bit: the serial data bit, sampled on each rising clk edge.
REQ-005 SHALL have port z, output, 1 bit: the detect pulse, registered and high for one cycle per match of 101010.
REQ-006 SHALL have port det_cnt, output, CNT_W bits: the number of detections since reset.

Function
REQ-007 SHALL detect the serial pattern 1,0,1,0,1,0 (first bit received first) on x.
REQ-008 SHALL implement a Moore FSM with seven states:
- IDLE: no prefix matched
- S1: matched "1"
- S10: matched "10"
- S101: matched "101"
- S1010: matched "1010"
- S10101: matched "10101"
- DET: matched "101010"
REQ-009 SHALL use these transitions (x=0 / x=1):
- IDLE -> IDLE / S1
- S1 -> S10 / S1
- S10 -> IDLE / S101
- S101 -> S1010 / S1
- S1010 -> IDLE / S10101
- S10101 -> DET / S1
- DET -> IDLE / (overlap target per REQ-019)
REQ-010 SHALL drive z=1 exactly while the state is DET and z=0 in every other state; z is decoded from the state register only, never combinationally from x.
REQ-011 SHALL give a latency such that z rises on the same rising edge that samples the sixth pattern bit and stays high for exactly one clk period, unless the next sample re-enters DET.
REQ-012 SHALL increment det_cnt by 1 on each edge that enters DET.
REQ-013 SHALL saturate det_cnt at 2^CNT_W-1 with no wrap-around.
REQ-014 SHALL leave z and det_cnt at 0 until a full pattern has been sampled after reset release.
REQ-015 SHALL treat unknown values on x as don't-care; benches SHALL drive only 0 or 1.

Reset
REQ-016 SHALL, while rst=0 and regardless of clk, force the state to IDLE, z=0 and det_cnt=0.
REQ-017 SHALL sample x first on the first rising clk edge after rst returns to 1.
REQ-018 SHALL, if rst is asserted mid-pattern (including in DET), discard the partial match and drop z immediately.

Configuration
REQ-019 SHALL gate overlapping detection with macro SEQ_DET_OVERLAP_EN:
- Defined: DET with x=1 goes to S10101, so a continued alternating stream reports a match every 2 bits.
- Undefined: DET with x=1 goes to S1, so matches are non-overlapping and at least 6 bits apart.
- All other transitions are identical in both builds.

Structure
REQ-020 SHALL place the FSM state typedef (3-bit encoding, IDLE=0) and the PATTERN constant 6'b101010 in package seq_det_pkg.
REQ-021 SHALL implement the saturating counter as sub-module seq_det_cnt, with inputs clk, rst and inc, and output the count.

Verification
REQ-022 Reset check: hold rst=0 for 12 time units with clk toggling and x random -> z=0 and det_cnt=0 throughout.
REQ-023 Alternating stream, overlap build: after reset, drive x=0,1,0,1,0,1,0,1,0,1,0,1 one bit per clock -> z pulses on the edges sampling bits 7, 9 and 11 (each 1 cycle); det_cnt ends at 3.
REQ-024 Same stream, non-overlap build -> z pulses only on the edge sampling bit 7; det_cnt ends at 1.
REQ-025 Near-misses: drive 1,0,1,1,0,1,0,1,0 -> one z pulse, on the final 0 only (recovery via S101 -> S1 on x=1).
REQ-026 Mid-pattern reset: drive 1,0,1,0,1, assert rst for 1 cycle, then drive 0 -> no z pulse; det_cnt stays 0.
REQ-027 Saturation: with CNT_W=2, drive 5 separate 101010 patterns -> det_cnt ends at 3 and z still pulses 5 times.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the 101010 serial pattern detector.
package seq_det_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_S1     = 3'd1,
    ST_S10    = 3'd2,
    ST_S101   = 3'd3,
    ST_S1010  = 3'd4,
    ST_S10101 = 3'd5,
    ST_DET    = 3'd6
  } state_t;

  // Transmitted MSB first: PATTERN[5] is the first bit on the wire.
  localparam logic [5:0] PATTERN = 6'b101010;

endpackage

// File: rtl/seq_det_if.sv
// Bundle of the detector's serial input and detection outputs.
interface seq_det_if #(
  parameter int unsigned CNT_W = 8
);

  logic             x;
  logic             z;
  logic [CNT_W-1:0] det_cnt;

  modport master (
    output x,
    input  z,
    input  det_cnt
  );

  modport slave (
    input  x,
    output z,
    output det_cnt
  );

endinterface

// File: rtl/seq_det_cnt.sv
// Saturating up-counter of detections; holds at all-ones instead of wrapping.
module seq_det_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= CNT_W'(r_cnt + 1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/seq_det.sv
// Moore detector for serial pattern 101010 with a saturating detection counter.
// Define SEQ_DET_OVERLAP_EN to let a match reuse its trailing "1010" for the next one.
module seq_det
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  output logic             z,
  output logic [CNT_W-1:0] det_cnt
);

`ifdef SEQ_DET_OVERLAP_EN
  localparam state_t DET_ON_ONE = ST_S10101;
`else
  localparam state_t DET_ON_ONE = ST_S1;
`endif

  state_t r_state;
  state_t w_next;
  logic   w_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = x ? ST_S1     : ST_IDLE;
      ST_S1:     w_next = x ? ST_S1     : ST_S10;
      ST_S10:    w_next = x ? ST_S101   : ST_IDLE;
      ST_S101:   w_next = x ? ST_S1     : ST_S1010;
      ST_S1010:  w_next = x ? ST_S10101 : ST_IDLE;
      ST_S10101: w_next = x ? ST_S1     : ST_DET;
      ST_DET:    w_next = x ? DET_ON_ONE : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // DET never self-loops, so every cycle whose next state is DET is a fresh entry.
  assign w_inc = (w_next == ST_DET);
  assign z     = (r_state == ST_DET);

  seq_det_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_inc),
    .cnt (det_cnt)
  );

endmodule

// File: tb/tb_seq_det.sv
// Directed bench for seq_det: an 8-bit counter instance plus a 2-bit instance sharing its stream.
module tb_seq_det;
  import seq_det_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  seq_det_if #(.CNT_W(8)) dif ();
  seq_det_if #(.CNT_W(2)) sif ();

  assign sif.x = dif.x;

  seq_det #(.CNT_W(8)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .x       (dif.x),
    .z       (dif.z),
    .det_cnt (dif.det_cnt)
  );

  seq_det #(.CNT_W(2)) u_sat (
    .clk     (clk),
    .rst     (rst),
    .x       (sif.x),
    .z       (sif.z),
    .det_cnt (sif.det_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // bits[i] is the i-th bit sent; zexp[i] is z expected after the edge sampling it.
  task automatic run_stream(input string tag, input int n,
                            input logic [15:0] bits, input logic [15:0] zexp);
    for (int i = 0; i < n; i++) begin
      dif.x = bits[i];
      @(posedge clk);
      #1;
      check($sformatf("%s z[%0d]", tag, i), 32'(dif.z), 32'(zexp[i]));
      check($sformatf("%s sat_z[%0d]", tag, i), 32'(sif.z), 32'(zexp[i]));
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " z"}, 32'(dif.z), 0);
    check({tag, " cnt"}, 32'(dif.det_cnt), 0);
    check({tag, " sat_z"}, 32'(sif.z), 0);
    check({tag, " sat_cnt"}, 32'(sif.det_cnt), 0);
  endtask

  // Called #1 after a rising edge; releases at the following falling edge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #2;
    check_cleared(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    dif.x = 1'b0;

    // Reset held for 12 time units across clock edges with random x.
    for (int i = 0; i < 4; i++) begin
      #3;
      dif.x = 1'($urandom_range(0, 1));
      check_cleared($sformatf("por[%0d]", i));
    end
    rst = 1'b1;

    // Alternating stream 0,1,0,1,... twelve bits.
`ifdef SEQ_DET_OVERLAP_EN
    run_stream("alt", 12, 16'h0AAA, 16'h0540);
    check("alt cnt", 32'(dif.det_cnt), 3);
    check("alt sat_cnt", 32'(sif.det_cnt), 3);
`else
    run_stream("alt", 12, 16'h0AAA, 16'h0040);
    check("alt cnt", 32'(dif.det_cnt), 1);
    check("alt sat_cnt", 32'(sif.det_cnt), 1);
`endif

    // Near-miss 1,0,1,1,0,1,0,1,0 recovers through S101 -> S1.
    do_reset("rst_nm");
    run_stream("near", 9, 16'h00AD, 16'h0100);
    check("near cnt", 32'(dif.det_cnt), 1);

    // Reset mid-pattern after 1,0,1,0,1 discards the prefix.
    do_reset("rst_mid");
    run_stream("mid_pre", 5, 16'h0015, 16'h0000);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_cleared("mid_hold");
    rst = 1'b1;
    run_stream("mid_post", 1, 16'h0000, 16'h0000);
    check("mid cnt", 32'(dif.det_cnt), 0);

    // Reset asserted while in DET drops z without waiting for a clock.
    do_reset("rst_det");
    run_stream("det", 6, 16'h0015, 16'h0020);
    check("det cnt", 32'(dif.det_cnt), 1);
    rst = 1'b0;
    #1;
    check_cleared("det_async");
    @(negedge clk);
    rst = 1'b1;

    // Five separated patterns: 8-bit counter reaches 5, 2-bit counter pins at 3.
    for (int k = 0; k < 5; k++) begin
      run_stream($sformatf("sat%0d", k), 7, 16'h0015, 16'h0020);
      check($sformatf("sat%0d cnt", k), 32'(dif.det_cnt), 32'(k + 1));
      check($sformatf("sat%0d sat_cnt", k), 32'(sif.det_cnt), 32'(sat_exp[k]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
